// File: rtl/bitwise_majority.sv
// Eight independent three-input majority voters with a registered output.
// Each lane votes ui_in, uio_in and its own previous result, forming a C-element.
module bitwise_majority (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int WIDTH = 8;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] m_next;

  // Majority of the two operands and the held value: agreement wins, disagreement holds.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign m_next[gi] = (ui_in[gi] & uio_in[gi])
                        | (ui_in[gi] & m_reg[gi])
                        | (uio_in[gi] & m_reg[gi]);
    end
  endgenerate

  // rst_n is an active-high synchronous reset despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      m_reg <= '0;
    end else if (ena) begin
      m_reg <= m_next;
    end
  end

  assign uo_out  = m_reg;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_bitwise_majority.sv
// Self-checking bench for bitwise_majority: directed scenarios plus randomized
// traffic checked against a lane-by-lane C-element reference model.
module tb_bitwise_majority;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_m = 8'hxx;

  bitwise_majority dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: reset clears, otherwise each enabled lane follows agreeing operands.
  task automatic tick();
    logic [7:0] nxt;
    nxt = model_m;
    if (rst_n) nxt = 8'h00;
    else if (ena) begin
      for (int i = 0; i < 8; i++)
        if (ui_in[i] == uio_in[i]) nxt[i] = ui_in[i];
    end
    @(posedge clk);
    model_m = nxt;
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
    rst_n = r; ena = e; ui_in = a; uio_in = b;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_uo: got %h expected %h", uo_out, 8'h00);
    end
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++; $display("FAIL reset_uio: got out=%h oe=%h expected 00/00", uio_out, uio_oe);
    end
    $display("reset: uo_out=%h", uo_out);
  endtask

  task automatic test_agreement();
    drive(1'b0, 1'b1, 8'hF0, 8'hF0);
    #2;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL agree_pre_edge: got %h expected %h", uo_out, 8'h00);
    end
    tick();
    checks++;
    if (uo_out !== 8'hF0) begin
      errors++; $display("FAIL agree: got %h expected %h", uo_out, 8'hF0);
    end
    $display("agree: A=F0 B=F0 uo_out=%h", uo_out);
  endtask

  task automatic test_partial();
    drive(1'b0, 1'b1, 8'hFF, 8'h0F);
    tick();
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++; $display("FAIL partial: got %h expected %h", uo_out, 8'hFF);
    end
    $display("partial: A=FF B=0F uo_out=%h", uo_out);
  endtask

  task automatic test_mixed();
    drive(1'b0, 1'b1, 8'h00, 8'hAA);
    tick();
    checks++;
    if (uo_out !== 8'hAA) begin
      errors++; $display("FAIL mixed: got %h expected %h", uo_out, 8'hAA);
    end
    $display("mixed: A=00 B=AA uo_out=%h", uo_out);
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (uo_out !== 8'hAA) begin
        errors++; $display("FAIL ena_hold%0d: got %h expected %h", k, uo_out, 8'hAA);
      end
    end
    ena = 1'b1;
    tick();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL ena_resume: got %h expected %h", uo_out, 8'h00);
    end
    $display("enable: held 3 edges then uo_out=%h", uo_out);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 8'h55, 8'h55);
    tick();
    checks++;
    if (uo_out !== 8'h55) begin
      errors++; $display("FAIL mid_setup: got %h expected %h", uo_out, 8'h55);
    end
    drive(1'b1, 1'b0, 8'hFF, 8'hFF);
    tick();
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got uo=%h uio_out=%h uio_oe=%h expected 00/00/00",
                         uo_out, uio_out, uio_oe);
    end
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    tick();
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++; $display("FAIL mid_release: got %h expected %h", uo_out, 8'hFF);
    end
    $display("reset_mid: after release uo_out=%h", uo_out);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), a, b);
      tick();
      // Glitch the inputs between edges; only the values present at the edge matter.
      ui_in = ~a; uio_in = ~b;
      #2;
      checks++;
      if (uo_out !== model_m || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL random%0d: got uo=%h uio_out=%h uio_oe=%h expected %h/00/00",
                 n, uo_out, uio_out, uio_oe, model_m);
      end
    end
    $display("random: 300 cycles compared against model");
  endtask

  initial begin
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    #1;
    test_reset();
    test_agreement();
    test_partial();
    test_mixed();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
